// File: rtl/eth_stats_pkg.sv
// Shared types and default widths for the Ethernet statistics updater.
package eth_stats_pkg;

   localparam int CNT_WIDTH_DEF   = 64;
   localparam int BYTES_WIDTH_DEF = 16;

   typedef struct packed {
      logic [BYTES_WIDTH_DEF-1:0] bytes;
      logic                       good;
   } stats_event_t;

   typedef enum logic {
      SRC_TX = 1'b0,
      SRC_RX = 1'b1
   } src_e;

   typedef struct packed {
      logic [CNT_WIDTH_DEF-1:0] bytes;
      logic [CNT_WIDTH_DEF-1:0] good;
      logic [CNT_WIDTH_DEF-1:0] bad;
   } stats_acc_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } snap_state_e;

endpackage

// File: rtl/eth_stats_event_slot.sv
// One-entry holding register for a per-frame result, with a sticky drop flag.
module eth_stats_event_slot #(
   parameter int BYTES_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_i,
   input  logic [BYTES_WIDTH-1:0] bytes_i,
   input  logic                   good_i,
   input  logic                   grant_i,
   input  logic                   ovf_clr_i,
   output logic                   pending_o,
   output logic [BYTES_WIDTH-1:0] bytes_o,
   output logic                   good_o,
   output logic                   overflow_o
);

   logic                   pending_q, pending_d;
   logic [BYTES_WIDTH-1:0] bytes_q, bytes_d;
   logic                   good_q, good_d;
   logic                   ovf_q, ovf_d;
   logic                   accept;
   logic                   drop;

   // Load when the slot is empty or being drained this cycle; otherwise the new result is lost.
   always_comb begin
      accept    = load_i & (~pending_q | grant_i);
      drop      = load_i & pending_q & ~grant_i;
      pending_d = accept | (pending_q & ~grant_i);
      bytes_d   = accept ? bytes_i : bytes_q;
      good_d    = accept ? good_i  : good_q;
      // A drop in the clearing cycle is a new event and must stay visible.
      ovf_d     = (ovf_q & ~ovf_clr_i) | drop;
   end

   // Slot state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= 1'b0;
         bytes_q   <= '0;
         good_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         bytes_q   <= bytes_d;
         good_q    <= good_d;
         ovf_q     <= ovf_d;
      end
   end

   assign pending_o  = pending_q;
   assign bytes_o    = bytes_q;
   assign good_o     = good_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/eth_stats_updater.sv
// Shared TX/RX statistics accumulators with round-robin update path and
// four-phase snapshot/clear handshake.
//
// Snapshot FSM:
//   state  | meaning
//   S_IDLE | waiting for snapshot_req; snapshot taken on the edge that sees it
//   S_ACK  | snapshot_ack high; waiting for snapshot_req to drop
module eth_stats_updater
   import eth_stats_pkg::*;
#(
   parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
   parameter int BYTES_WIDTH = BYTES_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [BYTES_WIDTH-1:0] tx_frame_bytes,
   input  logic                   tx_frame_good,
   input  logic                   tx_valid,
   input  logic [BYTES_WIDTH-1:0] rx_frame_bytes,
   input  logic                   rx_frame_good,
   input  logic                   rx_valid,
   input  logic                   snapshot_req,
   input  logic                   snapshot_clear,
   output logic                   snapshot_ack,
   output logic [CNT_WIDTH-1:0]   snap_tx_bytes,
   output logic [CNT_WIDTH-1:0]   snap_tx_good,
   output logic [CNT_WIDTH-1:0]   snap_tx_bad,
   output logic [CNT_WIDTH-1:0]   snap_rx_bytes,
   output logic [CNT_WIDTH-1:0]   snap_rx_good,
   output logic [CNT_WIDTH-1:0]   snap_rx_bad,
   output logic [1:0]             overflow
);

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   logic                   tx_pend, rx_pend;
   logic [BYTES_WIDTH-1:0] tx_ev_bytes, rx_ev_bytes;
   logic                   tx_ev_good, rx_ev_good;
   logic                   gnt_tx, gnt_rx;
   src_e                   rr_last_q, rr_last_d;

   snap_state_e            state_q, state_d;
   logic                   snap_load;
   logic                   clear_now;

   logic [CNT_WIDTH-1:0]   tx_bytes_q, tx_bytes_d, tx_good_q, tx_good_d, tx_bad_q, tx_bad_d;
   logic [CNT_WIDTH-1:0]   rx_bytes_q, rx_bytes_d, rx_good_q, rx_good_d, rx_bad_q, rx_bad_d;
   logic [CNT_WIDTH-1:0]   snap_tx_bytes_q, snap_tx_good_q, snap_tx_bad_q;
   logic [CNT_WIDTH-1:0]   snap_rx_bytes_q, snap_rx_good_q, snap_rx_bad_q;

   eth_stats_event_slot #(.BYTES_WIDTH(BYTES_WIDTH)) u_tx_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tx_valid & enable),
      .bytes_i    (tx_frame_bytes),
      .good_i     (tx_frame_good),
      .grant_i    (gnt_tx),
      .ovf_clr_i  (clear_now),
      .pending_o  (tx_pend),
      .bytes_o    (tx_ev_bytes),
      .good_o     (tx_ev_good),
      .overflow_o (overflow[0])
   );

   eth_stats_event_slot #(.BYTES_WIDTH(BYTES_WIDTH)) u_rx_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (rx_valid & enable),
      .bytes_i    (rx_frame_bytes),
      .good_i     (rx_frame_good),
      .grant_i    (gnt_rx),
      .ovf_clr_i  (clear_now),
      .pending_o  (rx_pend),
      .bytes_o    (rx_ev_bytes),
      .good_o     (rx_ev_good),
      .overflow_o (overflow[1])
   );

   // Round-robin grant: a lone pending slot always wins, a tie goes to the source not served last.
   always_comb begin
      gnt_tx    = tx_pend & (~rx_pend | (rr_last_q == SRC_RX));
      gnt_rx    = rx_pend & ~gnt_tx;
      rr_last_d = rr_last_q;
      if (gnt_tx) rr_last_d = SRC_TX;
      else if (gnt_rx) rr_last_d = SRC_RX;
   end

   // Snapshot FSM next state; snapshot and optional clear happen on the IDLE edge that sees req.
   always_comb begin
      state_d   = state_q;
      snap_load = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (snapshot_req) begin
               snap_load = 1'b1;
               state_d   = S_ACK;
            end
         end
         S_ACK: begin
            if (!snapshot_req) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      clear_now = snap_load & snapshot_clear;
   end

   // Accumulator next values: a clear restarts from zero, and a same-cycle grant lands in the new window.
   always_comb begin
      tx_bytes_d = clear_now ? '0 : tx_bytes_q;
      tx_good_d  = clear_now ? '0 : tx_good_q;
      tx_bad_d   = clear_now ? '0 : tx_bad_q;
      rx_bytes_d = clear_now ? '0 : rx_bytes_q;
      rx_good_d  = clear_now ? '0 : rx_good_q;
      rx_bad_d   = clear_now ? '0 : rx_bad_q;
      if (gnt_tx) begin
         tx_bytes_d = tx_bytes_d + CNT_WIDTH'(tx_ev_bytes);
         if (tx_ev_good) tx_good_d = tx_good_d + ONE;
         else            tx_bad_d  = tx_bad_d + ONE;
      end
      if (gnt_rx) begin
         rx_bytes_d = rx_bytes_d + CNT_WIDTH'(rx_ev_bytes);
         if (rx_ev_good) rx_good_d = rx_good_d + ONE;
         else            rx_bad_d  = rx_bad_d + ONE;
      end
   end

   // Control state: arbitration pointer and snapshot FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q <= SRC_RX;
         state_q   <= S_IDLE;
      end else begin
         rr_last_q <= rr_last_d;
         state_q   <= state_d;
      end
   end

   // Accumulators, wrapping naturally at the counter width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_bytes_q <= '0;
         tx_good_q  <= '0;
         tx_bad_q   <= '0;
         rx_bytes_q <= '0;
         rx_good_q  <= '0;
         rx_bad_q   <= '0;
      end else begin
         tx_bytes_q <= tx_bytes_d;
         tx_good_q  <= tx_good_d;
         tx_bad_q   <= tx_bad_d;
         rx_bytes_q <= rx_bytes_d;
         rx_good_q  <= rx_good_d;
         rx_bad_q   <= rx_bad_d;
      end
   end

   // Snapshot registers capture pre-update accumulator values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_tx_bytes_q <= '0;
         snap_tx_good_q  <= '0;
         snap_tx_bad_q   <= '0;
         snap_rx_bytes_q <= '0;
         snap_rx_good_q  <= '0;
         snap_rx_bad_q   <= '0;
      end else if (snap_load) begin
         snap_tx_bytes_q <= tx_bytes_q;
         snap_tx_good_q  <= tx_good_q;
         snap_tx_bad_q   <= tx_bad_q;
         snap_rx_bytes_q <= rx_bytes_q;
         snap_rx_good_q  <= rx_good_q;
         snap_rx_bad_q   <= rx_bad_q;
      end
   end

   assign snapshot_ack  = (state_q == S_ACK);
   assign snap_tx_bytes = snap_tx_bytes_q;
   assign snap_tx_good  = snap_tx_good_q;
   assign snap_tx_bad   = snap_tx_bad_q;
   assign snap_rx_bytes = snap_rx_bytes_q;
   assign snap_rx_good  = snap_rx_good_q;
   assign snap_rx_bad   = snap_rx_bad_q;

endmodule

// File: tb/tb_eth_stats_updater.sv
// Directed testbench for eth_stats_updater.
module tb_eth_stats_updater;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [15:0] tx_frame_bytes, rx_frame_bytes;
   logic        tx_frame_good, rx_frame_good;
   logic        tx_valid, rx_valid;
   logic        snapshot_req, snapshot_clear;
   logic        snapshot_ack;
   logic [63:0] snap_tx_bytes, snap_tx_good, snap_tx_bad;
   logic [63:0] snap_rx_bytes, snap_rx_good, snap_rx_bad;
   logic [1:0]  overflow;

   int checks = 0;
   int errors = 0;

   logic [63:0] m_tx_b, m_tx_g, m_tx_x, m_rx_b, m_rx_g, m_rx_x;
   logic [63:0] s_tx_b, s_tx_g, s_tx_x, s_rx_b, s_rx_g, s_rx_x;
   int          sent;
   logic [15:0] rb;
   logic        rg;

   eth_stats_updater dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .tx_frame_bytes (tx_frame_bytes),
      .tx_frame_good  (tx_frame_good),
      .tx_valid       (tx_valid),
      .rx_frame_bytes (rx_frame_bytes),
      .rx_frame_good  (rx_frame_good),
      .rx_valid       (rx_valid),
      .snapshot_req   (snapshot_req),
      .snapshot_clear (snapshot_clear),
      .snapshot_ack   (snapshot_ack),
      .snap_tx_bytes  (snap_tx_bytes),
      .snap_tx_good   (snap_tx_good),
      .snap_tx_bad    (snap_tx_bad),
      .snap_rx_bytes  (snap_rx_bytes),
      .snap_rx_good   (snap_rx_good),
      .snap_rx_bad    (snap_rx_bad),
      .overflow       (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_acc(input string tag, input logic [63:0] b, g, x,
                          input logic [63:0] eb, eg, ex);
      chk({tag, ".bytes"}, b, eb);
      chk({tag, ".good"},  g, eg);
      chk({tag, ".bad"},   x, ex);
   endtask

   task automatic idle_inputs();
      tx_valid = 0; rx_valid = 0;
      tx_frame_bytes = '0; rx_frame_bytes = '0;
      tx_frame_good = 0; rx_frame_good = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      idle_inputs();
      enable = 1; snapshot_req = 0; snapshot_clear = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   // Full handshake; ack must rise one cycle after req and fall one cycle after req drops.
   task automatic snap_take(input logic clr);
      snapshot_req = 1; snapshot_clear = clr;
      @(negedge clk);
      chk("ack_rise", {63'd0, snapshot_ack}, 64'd1);
      s_tx_b = snap_tx_bytes; s_tx_g = snap_tx_good; s_tx_x = snap_tx_bad;
      s_rx_b = snap_rx_bytes; s_rx_g = snap_rx_good; s_rx_x = snap_rx_bad;
      snapshot_req = 0; snapshot_clear = 0;
      @(negedge clk);
      chk("ack_fall", {63'd0, snapshot_ack}, 64'd0);
   endtask

   initial begin
      rst_n = 0;
      do_reset();
      @(negedge clk);

      // Reset state
      chk("rst_ack", {63'd0, snapshot_ack}, 64'd0);
      chk("rst_ovf", {62'd0, overflow}, 64'd0);
      chk_acc("rst_snap_tx", snap_tx_bytes, snap_tx_good, snap_tx_bad, 0, 0, 0);
      chk_acc("rst_snap_rx", snap_rx_bytes, snap_rx_good, snap_rx_bad, 0, 0, 0);

      // Single TX frame of 64 good bytes
      tx_valid = 1; tx_frame_bytes = 16'd64; tx_frame_good = 1;
      @(negedge clk); idle_inputs();
      @(negedge clk);
      chk_acc("t1_tx_acc", dut.tx_bytes_q, dut.tx_good_q, dut.tx_bad_q, 64, 1, 0);
      snap_take(1'b0);
      chk_acc("t1_snap_tx", s_tx_b, s_tx_g, s_tx_x, 64, 1, 0);
      chk_acc("t1_snap_rx", s_rx_b, s_rx_g, s_rx_x, 0, 0, 0);

      // Simultaneous TX/RX, then a TX reload that ties with pending RX
      do_reset();
      @(negedge clk);
      tx_valid = 1; tx_frame_bytes = 16'd100; tx_frame_good = 1;
      rx_valid = 1; rx_frame_bytes = 16'd60;  rx_frame_good = 0;
      @(negedge clk); idle_inputs();
      tx_valid = 1; tx_frame_bytes = 16'd40; tx_frame_good = 1;
      chk("t2_tx_before", dut.tx_bytes_q, 64'd0);
      @(negedge clk); idle_inputs();
      chk_acc("t2_tx_first", dut.tx_bytes_q, dut.tx_good_q, dut.tx_bad_q, 100, 1, 0);
      chk("t2_rx_wait", dut.rx_bytes_q, 64'd0);
      @(negedge clk);
      chk_acc("t2_rx_acc", dut.rx_bytes_q, dut.rx_good_q, dut.rx_bad_q, 60, 0, 1);
      chk("t2_tx_held", dut.tx_bytes_q, 64'd100);
      @(negedge clk);
      chk_acc("t2_tx_second", dut.tx_bytes_q, dut.tx_good_q, dut.tx_bad_q, 140, 2, 0);

      // Snapshot with clear coincident with a TX grant
      do_reset();
      @(negedge clk);
      tx_valid = 1; tx_frame_bytes = 16'd200; tx_frame_good = 1;
      rx_valid = 1; rx_frame_bytes = 16'd300; rx_frame_good = 1;
      @(negedge clk); idle_inputs();
      repeat (2) @(negedge clk);
      tx_valid = 1; tx_frame_bytes = 16'd1514; tx_frame_good = 1;
      @(negedge clk); idle_inputs();
      chk("t3_ack_low", {63'd0, snapshot_ack}, 64'd0);
      snap_take(1'b1);
      chk_acc("t3_snap_tx", s_tx_b, s_tx_g, s_tx_x, 200, 1, 0);
      chk_acc("t3_snap_rx", s_rx_b, s_rx_g, s_rx_x, 300, 1, 0);
      chk_acc("t3_tx_acc", dut.tx_bytes_q, dut.tx_good_q, dut.tx_bad_q, 1514, 1, 0);
      chk_acc("t3_rx_acc", dut.rx_bytes_q, dut.rx_good_q, dut.rx_bad_q, 0, 0, 0);

      // Illegal back-to-back TX while RX holds the grant
      do_reset();
      @(negedge clk);
      tx_valid = 1; tx_frame_bytes = 16'd5; tx_frame_good = 1;
      @(negedge clk); idle_inputs();
      @(negedge clk);
      tx_valid = 1; tx_frame_bytes = 16'd10; tx_frame_good = 1;
      rx_valid = 1; rx_frame_bytes = 16'd50; rx_frame_good = 1;
      @(negedge clk); idle_inputs();
      tx_valid = 1; tx_frame_bytes = 16'd20; tx_frame_good = 1;
      @(negedge clk); idle_inputs();
      chk("t4_ovf_set", {62'd0, overflow}, 64'd1);
      chk_acc("t4_rx_acc", dut.rx_bytes_q, dut.rx_good_q, dut.rx_bad_q, 50, 1, 0);
      @(negedge clk);
      chk_acc("t4_tx_acc", dut.tx_bytes_q, dut.tx_good_q, dut.tx_bad_q, 15, 2, 0);
      enable = 0;
      tx_valid = 1; tx_frame_bytes = 16'd7; tx_frame_good = 1;
      @(negedge clk);
      @(negedge clk); idle_inputs();
      enable = 1;
      @(negedge clk);
      chk("t4_dis_tx", dut.tx_bytes_q, 64'd15);
      chk("t4_ovf_sticky", {62'd0, overflow}, 64'd1);
      snap_take(1'b1);
      chk_acc("t4_snap_tx", s_tx_b, s_tx_g, s_tx_x, 15, 2, 0);
      chk("t4_ovf_clr", {62'd0, overflow}, 64'd0);

      // Legal traffic on both sources with periodic snapshot/clear
      do_reset();
      m_tx_b = 0; m_tx_g = 0; m_tx_x = 0; m_rx_b = 0; m_rx_g = 0; m_rx_x = 0;
      sent = 0;
      for (int t = 0; t < 2080; t++) begin
         @(negedge clk);
         if (snapshot_req && snapshot_ack) begin
            m_tx_b -= snap_tx_bytes; m_tx_g -= snap_tx_good; m_tx_x -= snap_tx_bad;
            m_rx_b -= snap_rx_bytes; m_rx_g -= snap_rx_good; m_rx_x -= snap_rx_bad;
            snapshot_req = 0; snapshot_clear = 0;
         end else if ((t % 37) == 0 && t < 2040 && !snapshot_req && !snapshot_ack) begin
            snapshot_req = 1; snapshot_clear = 1;
         end
         idle_inputs();
         if ((t % 2) == 0 && sent < 1000) begin
            rb = 16'($urandom_range(1518, 64)); rg = 1'($urandom_range(1, 0));
            tx_valid = 1; tx_frame_bytes = rb; tx_frame_good = rg;
            m_tx_b += 64'(rb); if (rg) m_tx_g += 1; else m_tx_x += 1;
            rb = 16'($urandom_range(1518, 64)); rg = 1'($urandom_range(1, 0));
            rx_valid = 1; rx_frame_bytes = rb; rx_frame_good = rg;
            m_rx_b += 64'(rb); if (rg) m_rx_g += 1; else m_rx_x += 1;
            sent++;
         end
      end
      idle_inputs();
      snap_take(1'b1);
      chk_acc("t5_tx_remain", s_tx_b, s_tx_g, s_tx_x, m_tx_b, m_tx_g, m_tx_x);
      chk_acc("t5_rx_remain", s_rx_b, s_rx_g, s_rx_x, m_rx_b, m_rx_g, m_rx_x);
      chk("t5_ovf", {62'd0, overflow}, 64'd0);

      // Byte counter wrap, then async reset in the middle of a handshake
      do_reset();
      @(negedge clk);
      force dut.tx_bytes_q = 64'hFFFF_FFFF_FFFF_FFF6;
      @(negedge clk);
      release dut.tx_bytes_q;
      tx_valid = 1; tx_frame_bytes = 16'd20; tx_frame_good = 1;
      @(negedge clk); idle_inputs();
      @(negedge clk);
      chk_acc("t6_wrap", dut.tx_bytes_q, dut.tx_good_q, dut.tx_bad_q, 10, 1, 0);
      snapshot_req = 1;
      @(negedge clk);
      chk("t6_ack", {63'd0, snapshot_ack}, 64'd1);
      chk("t6_snap_b", snap_tx_bytes, 64'd10);
      #2 rst_n = 0;
      #1;
      chk("t6_rst_ack", {63'd0, snapshot_ack}, 64'd0);
      chk_acc("t6_rst_snap_tx", snap_tx_bytes, snap_tx_good, snap_tx_bad, 0, 0, 0);
      chk("t6_rst_ovf", {62'd0, overflow}, 64'd0);
      chk("t6_rst_acc", dut.tx_bytes_q, 64'd0);
      do_reset();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_stats_updater.md
Name: eth_stats_updater

Overview:
- Shares one set of per-port statistics accumulators, with a single read-modify-write update path, between the TX and RX per-frame stats counters.
- Each counter emits one {frame_bytes, frame_good, valid} result per frame. This block buffers each result in a one-entry slot, arbitrates round-robin and accumulates totals.
- Serves a four-phase snapshot/clear handshake to the register interface.
- Sits between the TX/RX stats counters and the AXI-Lite register block of the stats collector.

Parameters:
- CNT_WIDTH, 64, width of every accumulator and snapshot register
- BYTES_WIDTH, 16, width of per-frame byte count inputs

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  1 = accept new frame results; 0 = ignore incoming valid pulses
- tx_frame_bytes  in  BYTES_WIDTH  TX frame length in bytes, saturated upstream
- tx_frame_good  in  1  TX frame completed without underrun
- tx_valid  in  1  one-cycle pulse: TX result present
- rx_frame_bytes / rx_frame_good / rx_valid  in  BYTES_WIDTH/1/1  same for RX
- snapshot_req  in  1  level request, four-phase
- snapshot_clear  in  1  sampled with snapshot_req; 1 = zero accumulators at snapshot
- snapshot_ack  out  1  four-phase acknowledge
- snap_tx_bytes, snap_tx_good, snap_tx_bad  out  CNT_WIDTH  TX snapshot: bytes, good frames, bad frames
- snap_rx_bytes, snap_rx_good, snap_rx_bad  out  CNT_WIDTH  RX snapshot, same fields
- overflow  out  2  sticky dropped-result flags, bit0 TX, bit1 RX

Behaviour:
- Reset (async, rst_n=0):
  - all accumulators, snapshots, slots and overflow go to 0; snapshot_ack=0
  - RR pointer = "last served RX", so TX wins the first tie
  - reset mid-frame or mid-handshake discards everything in flight
- Capture:
  - x_valid=1 and enable=1 at edge N loads {bytes, good} into slot x; pending=1 after edge N.
  - If slot x is already pending and not granted in that cycle, the new result is dropped and overflow[x] is set.
  - If slot x is granted in the same cycle, the new result loads and nothing is lost.
- Arbitration: one grant per cycle among pending slots.
  - Single pending slot: that slot is granted.
  - Both pending: grant the slot not served last; the pointer updates on every grant.
- Update, at the edge ending the grant cycle:
  - bytes += zero-extended frame_bytes, for good and bad frames alike
  - good frame: good += 1; bad frame: bad += 1
  - the granted slot's pending flag clears unless it reloads
- Width rule: accumulators wrap modulo 2^CNT_WIDTH with no saturation.
- Latency: valid at cycle N → accumulator updated at edge N+1 when granted immediately; worst case N+2.
- Throughput: under legal input (≤1 result per source per 2 cycles), no result is ever dropped.
- Snapshot FSM:
  - states S_IDLE, S_ACK
  - S_IDLE with snapshot_req=1: snapshot registers load the pre-update accumulator values at that edge, then go to S_ACK
  - S_ACK: snapshot_ack=1; on snapshot_req=0 go to S_IDLE with ack=0 the next cycle
- Clear:
  - If snapshot_clear=1 at the snapshot edge, all accumulators load 0, and overflow clears after being reflected in the snapshot cycle.
  - If an update is granted in the same cycle, that source's accumulators load 0 plus the event contribution. The frame is counted in the next window, never lost.
  - Pending slots are unaffected by a clear.
- Simultaneous snapshot and update: both occur in one cycle; the snapshot excludes that update.
- enable=0: already-pending slots still drain; new pulses are ignored and do not set overflow.

Decomposition:
- Package eth_stats_pkg:
  - stats_event_t {bytes[BYTES_WIDTH], good}
  - src_e {SRC_TX=0, SRC_RX=1}
  - stats_acc_t {bytes, good, bad}, each CNT_WIDTH
  - default width constants
- Sub-module eth_stats_event_slot: one-entry holding register with load/grant/pending/overflow, instantiated once per source.

Test Plan:
- TX pulse bytes=64, good=1 → after 2 cycles the TX accumulator reads {64,1,0}; snapshot then returns the same values, RX reads all zeros.
- TX and RX pulses in the same cycle (100 good, 60 bad) → TX granted first, RX one cycle later; RX accumulator reads {60,0,1}; the following tie goes to RX.
- Back-to-back legal traffic: both sources pulse every 2 cycles, 1000 frames each, with snapshots every 37 cycles → per-window sums match the model exactly; overflow=0.
- Snapshot with clear coincident with a TX grant of 1514 bytes → snapshot excludes it; TX accumulator reads {1514,1,0}, RX reads 0; ack rises 1 cycle after req and falls 1 cycle after req drops.
- Forced illegal TX pulses on consecutive cycles while RX holds the grant → exactly one result dropped; overflow=2'b01 until a snapshot with clear.
- Accumulator preloaded to 2^64−10 via force, then a 20-byte frame → bytes wraps to 10; rst_n asserted mid-handshake → ack and all outputs 0 asynchronously.
